// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC generation, synchronous instruction SRAM request, and IF->ID handshake.
// Optional fetch-address alignment exception is enabled by defining IF_EXC_ADEF_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic        pc_allowin,
  output logic [31:0] npc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_to_ds_pc,
  output logic [31:0] fs_to_ds_inst,
  output logic        fs_to_ds_ex,
  output logic        dbg_state
);

  // Handshake: IF presents {pc, inst} while fs_to_ds_valid=1; a transfer
  // happens on a rising edge where fs_to_ds_valid && ds_allowin, and
  // fs_to_ds_* must hold stable while ds_allowin=0.

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        fs_valid_q, fs_valid_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        br_pending_q, br_pending_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] inst_sel;

  always_comb begin
    state_d        = state_q;
    fs_valid_d     = fs_valid_q;
    buf_valid_d    = buf_valid_q;
    inst_buf_d     = inst_buf_q;
    br_pending_d   = br_pending_q;
    pend_target_d  = pend_target_q;
    pc_allowin     = 1'b0;
    inst_sram_en   = 1'b0;

    if (br_pending_q)  npc = pend_target_q;
    else if (br_taken) npc = br_target;
    else               npc = pc + 32'd4;
    inst_sram_addr = npc;

    case (state_q)
      S_BOOT: begin
        // The PC register already holds RESET_PC, so only the SRAM is asked.
        inst_sram_en   = rst_n;
        inst_sram_addr = RESET_PC;
        state_d        = S_RUN;
        fs_valid_d     = 1'b1;
      end
      S_RUN: begin
        pc_allowin   = rst_n && (!fs_valid_q || ds_allowin);
        inst_sram_en = pc_allowin;
      end
      default: state_d = S_BOOT;
    endcase

    if (pc_allowin) begin
      fs_valid_d   = 1'b1;
      buf_valid_d  = 1'b0;
      br_pending_d = 1'b0;
    end else if (br_taken) begin
      br_pending_d  = 1'b1;
      pend_target_d = br_target;
    end

    // Capture the returned word on the first stalled cycle; the SRAM output
    // is not guaranteed to hold afterwards.
    if (fs_valid_q && !ds_allowin && !buf_valid_q) begin
      buf_valid_d = 1'b1;
      inst_buf_d  = inst_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_BOOT;
      fs_valid_q    <= 1'b0;
      buf_valid_q   <= 1'b0;
      inst_buf_q    <= 32'd0;
      br_pending_q  <= 1'b0;
      pend_target_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      fs_valid_q    <= fs_valid_d;
      buf_valid_q   <= buf_valid_d;
      inst_buf_q    <= inst_buf_d;
      br_pending_q  <= br_pending_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign inst_sel       = buf_valid_q ? inst_buf_q : inst_sram_rdata;
  assign fs_to_ds_valid = rst_n && fs_valid_q;
  assign fs_to_ds_pc    = pc;
  assign dbg_state      = state_q;

`ifdef IF_EXC_ADEF_EN
  logic adef;
  assign adef          = rst_n && fs_valid_q && (pc[1:0] != 2'b00);
  assign fs_to_ds_ex   = adef;
  assign fs_to_ds_inst = adef ? 32'd0 : inst_sel;
`else
  assign fs_to_ds_ex   = 1'b0;
  assign fs_to_ds_inst = inst_sel;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: PC register and synchronous SRAM models, a
// delivery scoreboard on the IF->ID handshake, and step-by-step output checks.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_allowin;
  logic [31:0] npc;
  logic        br_taken;
  logic [31:0] br_target;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [31:0] fs_to_ds_pc;
  logic [31:0] fs_to_ds_inst;
  logic        fs_to_ds_ex;
  logic        dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sb_e;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_allowin(pc_allowin), .npc(npc),
    .br_taken(br_taken), .br_target(br_target),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata), .ds_allowin(ds_allowin),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_pc(fs_to_ds_pc),
    .fs_to_ds_inst(fs_to_ds_inst), .fs_to_ds_ex(fs_to_ds_ex),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset-domain models ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #20000;
    $error("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  function automatic logic exp_ex(input logic [31:0] a);
`ifdef IF_EXC_ADEF_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] a);
    return exp_ex(a) ? 32'd0 : inst_of(a);
  endfunction

  // PC register and SRAM: unrequested cycles return garbage.
  always @(posedge clk) begin
    if (!rst_n)          pc <= RESET_PC;
    else if (pc_allowin) pc <= npc;
    inst_sram_rdata <= inst_sram_en ? inst_of(inst_sram_addr) : $urandom();
  end

  // ---------------- driver / check tasks ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && fs_to_ds_valid && ds_allowin) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("FAIL sb_extra observed=%h expected=none", fs_to_ds_pc);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_pc", fs_to_ds_pc, sb_e);
        chk("sb_inst", fs_to_ds_inst, exp_inst(sb_e));
        chk("sb_ex", {31'd0, fs_to_ds_ex}, {31'd0, exp_ex(sb_e)});
      end
    end
    if (rst_n && br_taken)
      chk("br_overlap", {31'd0, dut.br_pending_q}, 32'd0);
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; ds_allowin = 1'b1; br_taken = 1'b0; br_target = 32'd0;
    exp_q = '{32'h0040_0000, 32'h0040_0004, 32'h0040_0008, 32'h0040_000C,
              32'h0040_0010, 32'h0040_0014, 32'h0040_0100, 32'h0040_0104,
              32'h0040_0200, 32'h0040_0204,
              32'h0040_0000, 32'h0040_0004, 32'h0040_0102, 32'h0040_0106};

    nxt(); #1;
    chk("rst_valid", {31'd0, fs_to_ds_valid}, 32'd0);
    chk("rst_allowin", {31'd0, pc_allowin}, 32'd0);
    chk("rst_en", {31'd0, inst_sram_en}, 32'd0);
    chk("rst_ex", {31'd0, fs_to_ds_ex}, 32'd0);
    nxt(); nxt();

    rst_n = 1'b1; #1;
    chk("boot_state", {31'd0, dbg_state}, 32'd0);
    chk("boot_en", {31'd0, inst_sram_en}, 32'd1);
    chk("boot_addr", inst_sram_addr, 32'h0040_0000);
    chk("boot_allowin", {31'd0, pc_allowin}, 32'd0);
    chk("boot_valid", {31'd0, fs_to_ds_valid}, 32'd0);

    nxt(); #1;
    chk("c2_valid", {31'd0, fs_to_ds_valid}, 32'd1);
    chk("c2_pc", fs_to_ds_pc, 32'h0040_0000);
    chk("c2_inst", fs_to_ds_inst, inst_of(32'h0040_0000));
    chk("c2_npc", npc, 32'h0040_0004);
    chk("c2_addr", inst_sram_addr, 32'h0040_0004);
    nxt(); #1; chk("c3_pc", fs_to_ds_pc, 32'h0040_0004);
    nxt(); #1; chk("c4_pc", fs_to_ds_pc, 32'h0040_0008);

    // Four-cycle decode stall with garbage on the SRAM bus.
    nxt(); ds_allowin = 1'b0; #1;
    chk("stall_pc", fs_to_ds_pc, 32'h0040_000C);
    chk("stall_allowin", {31'd0, pc_allowin}, 32'd0);
    chk("stall_en", {31'd0, inst_sram_en}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      nxt(); #1;
      chk("stall_inst", fs_to_ds_inst, inst_of(32'h0040_000C));
      chk("stall_allowin", {31'd0, pc_allowin}, 32'd0);
      chk("stall_en", {31'd0, inst_sram_en}, 32'd0);
      chk("stall_pc", fs_to_ds_pc, 32'h0040_000C);
    end
    nxt(); ds_allowin = 1'b1; #1;
    chk("rel_inst", fs_to_ds_inst, inst_of(32'h0040_000C));
    chk("rel_allowin", {31'd0, pc_allowin}, 32'd1);
    chk("rel_npc", npc, 32'h0040_0010);
    nxt(); #1;
    chk("post_pc", fs_to_ds_pc, 32'h0040_0010);
    chk("post_inst", fs_to_ds_inst, inst_of(32'h0040_0010));

    // Branch at 0x10 resolves while its delay slot 0x14 sits in IF.
    nxt(); br_taken = 1'b1; br_target = 32'h0040_0100; #1;
    chk("br_pc", fs_to_ds_pc, 32'h0040_0014);
    chk("br_npc", npc, 32'h0040_0100);
    chk("br_addr", inst_sram_addr, 32'h0040_0100);
    nxt(); br_taken = 1'b0; #1;
    chk("tgt_pc", fs_to_ds_pc, 32'h0040_0100);
    chk("tgt_npc", npc, 32'h0040_0104);

    // Redirect arriving during a stall is held until release.
    nxt(); ds_allowin = 1'b0; br_taken = 1'b1; br_target = 32'h0040_0200; #1;
    chk("pst_pc", fs_to_ds_pc, 32'h0040_0104);
    chk("pst_allowin", {31'd0, pc_allowin}, 32'd0);
    nxt(); br_taken = 1'b0; #1;
    chk("pst_pending", {31'd0, dut.br_pending_q}, 32'd1);
    chk("pst_npc", npc, 32'h0040_0200);
    chk("pst_inst", fs_to_ds_inst, inst_of(32'h0040_0104));
    nxt(); ds_allowin = 1'b1; #1;
    chk("prl_allowin", {31'd0, pc_allowin}, 32'd1);
    chk("prl_addr", inst_sram_addr, 32'h0040_0200);
    nxt(); #1;
    chk("ptg_pc", fs_to_ds_pc, 32'h0040_0200);
    chk("ptg_pending", {31'd0, dut.br_pending_q}, 32'd0);
    chk("ptg_npc", npc, 32'h0040_0204);
    nxt(); #1;
    chk("pseq_pc", fs_to_ds_pc, 32'h0040_0204);

    // Reset while stalled with a redirect pending.
    nxt(); ds_allowin = 1'b0; br_taken = 1'b1; br_target = 32'h0040_0300; #1;
    chk("rms_pc", fs_to_ds_pc, 32'h0040_0208);
    nxt(); br_taken = 1'b0; #1;
    chk("rms_pending", {31'd0, dut.br_pending_q}, 32'd1);
    rst_n = 1'b0; #1;
    chk("rms_valid", {31'd0, fs_to_ds_valid}, 32'd0);
    chk("rms_allowin", {31'd0, pc_allowin}, 32'd0);
    chk("rms_en", {31'd0, inst_sram_en}, 32'd0);
    nxt(); #1;
    chk("rms_state", {31'd0, dbg_state}, 32'd0);
    chk("rms_pending_clr", {31'd0, dut.br_pending_q}, 32'd0);
    chk("rms_target_clr", dut.pend_target_q, 32'd0);
    chk("rms_buf_clr", {31'd0, dut.buf_valid_q}, 32'd0);
    chk("rms_valid2", {31'd0, fs_to_ds_valid}, 32'd0);
    rst_n = 1'b1; ds_allowin = 1'b1; #1;
    chk("reboot_en", {31'd0, inst_sram_en}, 32'd1);
    chk("reboot_addr", inst_sram_addr, 32'h0040_0000);
    nxt(); #1;
    chk("reboot_pc", fs_to_ds_pc, 32'h0040_0000);
    chk("reboot_valid", {31'd0, fs_to_ds_valid}, 32'd1);

    // Redirect to a misaligned target.
    nxt(); br_taken = 1'b1; br_target = 32'h0040_0102; #1;
    chk("mis_br_pc", fs_to_ds_pc, 32'h0040_0004);
    chk("mis_br_npc", npc, 32'h0040_0102);
    nxt(); br_taken = 1'b0; #1;
    chk("mis_pc", fs_to_ds_pc, 32'h0040_0102);
    chk("mis_ex", {31'd0, fs_to_ds_ex}, {31'd0, exp_ex(32'h0040_0102)});
    chk("mis_inst", fs_to_ds_inst, exp_inst(32'h0040_0102));
    chk("mis_addr", inst_sram_addr, 32'h0040_0106);
    nxt(); #1;
    chk("mis2_pc", fs_to_ds_pc, 32'h0040_0106);
    nxt(); ds_allowin = 1'b0; #1;
    chk("end_pc", fs_to_ds_pc, 32'h0040_010A);
    nxt(); nxt(); #1;
    chk("sb_drain", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
